// File: rtl/seg7_scan.sv
// Multiplexed 4-digit hex 7-segment driver with per-frame snapshot of VAL/DP.
// Define SEG7_BLANK_LZ_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VAL,
  input  logic [3:0]  DP,
  input  logic        EN,
  output logic [11:0] SEG
);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shval_q, shval_d;
  logic [3:0]       shdp_q, shdp_d;
  logic [11:0]      seg_q, seg_d;
  logic             tick;
  logic             blank;
  logic [3:0]       nib;
  logic [6:0]       glyph;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick    = (presc_q == CNT_W'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    shval_d = shval_q;
    shdp_d  = shdp_q;
    // Snapshot on the same edge idx wraps 3 -> 0, so a frame never mixes values.
    if (tick && (idx_q == 2'd3)) begin
      shval_d = VAL;
      shdp_d  = DP;
    end
    nib   = shval_q[{idx_q, 2'b00} +: 4];
    blank = 1'b0;
`ifdef SEG7_BLANK_LZ_EN
    blank = (idx_q != 2'd0) && ((shval_q >> {idx_q, 2'b00}) == 16'd0);
`endif
    glyph = blank ? 7'h7F : font(nib);
    if (!EN || tick) seg_d = '1;
    else             seg_d = {~(4'b0001 << idx_q), ~shdp_q[idx_q], glyph};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      idx_q   <= '0;
      shval_q <= '0;
      shdp_q  <= '0;
      seg_q   <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      shval_q <= shval_d;
      shdp_q  <= shdp_d;
      seg_q   <= seg_d;
    end
  end

  assign SEG = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: cycle-accurate arithmetic model plus literal spot checks.
module tb_seg7_scan;

  localparam int unsigned S = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] VAL = '0;
  logic [3:0]  DP  = '0;
  logic        EN  = 1'b1;
  logic [11:0] SEG;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  seg7_scan #(.SCAN_DIV(S), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .VAL(VAL), .DP(DP), .EN(EN), .SEG(SEG)
  );

  always #5 CLK = ~CLK;

  logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // What digit d of a held value looks like when lit.
  function automatic logic [11:0] digit_seg(input int unsigned d, input logic [15:0] v,
                                            input logic [3:0] dp);
    logic [15:0] hi;
    logic [3:0]  an;
    logic [6:0]  g;
    hi = v >> (4 * d);
    g  = FONT[hi[3:0]];
`ifdef SEG7_BLANK_LZ_EN
    if (d != 0 && hi == 16'd0) g = 7'h7F;
`endif
    an = 4'hF;
    an[d] = 1'b0;
    return {an, ~dp[d], g};
  endfunction

  // Model: k counts edges since reset release; slot position and digit follow arithmetically.
  int unsigned k_m;
  logic [15:0] sv_m;
  logic [3:0]  sd_m;
  logic [11:0] exp_m;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_m   <= 0;
      sv_m  <= '0;
      sd_m  <= '0;
      exp_m <= 12'hFFF;
    end else begin
      if (!EN || (k_m % S) == S - 1) exp_m <= 12'hFFF;
      else                           exp_m <= digit_seg((k_m / S) % 4, sv_m, sd_m);
      if ((k_m % (4 * S)) == 4 * S - 1) begin
        sv_m <= VAL;
        sd_m <= DP;
      end
      k_m <= k_m + 1;
    end
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: SEG=%03h expected %03h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge CLK);
      if (cmp_en) check("model", SEG, exp_m);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Wait (bounded) for digit d to be lit, then compare against a literal.
  task automatic wait_digit(input string name, input int unsigned d, input logic [11:0] want);
    logic [3:0] an;
    an = 4'hF;
    an[d] = 1'b0;
    for (int i = 0; i < 8 * S; i++) begin
      @(negedge CLK);
      if (SEG[11:8] == an) begin
        check(name, SEG, want);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: digit %0d never lit, SEG=%03h expected %03h", name, d, SEG, want);
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // Reset hold and release
    wait_cycles(2);
    cmp_en = 1'b1;
    check("reset_hold", SEG, 12'hFFF);
    RST = 1'b0;
    wait_cycles(1);
    check("first_edge", SEG, 12'hEC0);
    wait_cycles(3);
    check("dark_slot_end", SEG, 12'hFFF);

    // Digit decode
    VAL = 16'h1234;
    wait_cycles(8 * S);
    wait_digit("dec_d0", 0, 12'hE99);
    wait_digit("dec_d1", 1, 12'hDB0);
    wait_digit("dec_d2", 2, 12'hBA4);
    wait_digit("dec_d3", 3, 12'h7F9);

    // Snapshot integrity: change mid-frame
    wait_digit("snap_d1", 1, 12'hDB0);
    VAL = 16'hABCD;
    wait_digit("snap_d2", 2, 12'hBA4);
    wait_digit("snap_d3", 3, 12'h7F9);
    wait_digit("snap_d0", 0, 12'hEA1);
    wait_digit("snap_d2n", 2, 12'hB83);

    // Decimal points and font
    VAL = 16'hF0F0;
    DP  = 4'b0101;
    wait_cycles(8 * S);
    wait_digit("dp_d0", 0, 12'hE40);
    wait_digit("dp_d1", 1, 12'hD8E);
    wait_digit("dp_d2", 2, 12'hB40);

    // Enable
    EN = 1'b0;
    wait_cycles(1);
    check("en_off", SEG, 12'hFFF);
    wait_cycles(2 * S + 1);
    check("en_off_hold", SEG, 12'hFFF);
    EN = 1'b1;
    wait_cycles(3 * S);

    // Async reset between edges
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check("async_rst", SEG, 12'hFFF);
    @(negedge CLK);
    RST = 1'b0;
    wait_cycles(1);
    check("rst_release", SEG, 12'hEC0);

    // Leading zeros
    VAL = 16'h0050;
    DP  = 4'b0000;
    wait_cycles(8 * S);
`ifdef SEG7_BLANK_LZ_EN
    wait_digit("lz_d3", 3, 12'h7FF);
    wait_digit("lz_d2", 2, 12'hBFF);
`else
    wait_digit("lz_d3", 3, 12'h7C0);
    wait_digit("lz_d2", 2, 12'hBC0);
`endif
    wait_digit("lz_d1", 1, 12'hD92);
    wait_digit("lz_d0", 0, 12'hEC0);
    VAL = 16'h0000;
    wait_cycles(8 * S);
    wait_digit("zero_d0", 0, 12'hEC0);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) VAL = 16'($urandom);
      if ($urandom_range(7) == 0) DP = 4'($urandom);
      if ($urandom_range(15) == 0) EN = ~EN;
      if ($urandom_range(499) == 0) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
